// File: rtl/heichips25_accum_sequencer.sv
// Operand FIFO feeding a time-shared 8-bit adder into a 16-bit accumulator,
// sequenced by a synchronized strobe/command handshake on the bidirectional pins.
module heichips25_accum_sequencer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [0:0] {StIdle, StSum} state_e;

    localparam logic [1:0] CmdLoad  = 2'b00;
    localparam logic [1:0] CmdRun   = 2'b01;
    localparam logic [1:0] CmdClear = 2'b10;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic [7:0]             mem_q [DEPTH];
    logic [PtrW-1:0]        wr_ptr_q;
    logic [PtrW-1:0]        rd_ptr_q;
    logic [CntW-1:0]        count_q;
    logic [15:0]            acc_q;
    logic                   ovf_q;

    logic       stb;
    logic [1:0] cmd;
    logic       byte_sel;
    logic       pulse;
    logic       empty;
    logic       full;
    logic       busy;
    logic [8:0] sum;
    logic       carry;
    logic       unused;

    assign stb      = uio_in[0];
    assign cmd      = uio_in[2:1];
    assign byte_sel = uio_in[3];
    assign unused   = ^{ena, uio_in[7:4]};

    assign pulse = sync_q[SYNC_STAGES-1] & ~edge_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(DEPTH));
    assign busy  = (state_q == StSum);

    assign sum   = {1'b0, acc_q[7:0]} + {1'b0, mem_q[rd_ptr_q]};
    assign carry = sum[8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sync_q   <= '0;
            edge_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= stb;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            edge_q <= sync_q[SYNC_STAGES-1];

            unique case (state_q)
                StIdle: begin
                    if (pulse) begin
                        case (cmd)
                            CmdLoad: begin
                                if (!full) begin
                                    mem_q[wr_ptr_q] <= ui_in;
                                    wr_ptr_q        <= wr_ptr_q + PtrW'(1);
                                    count_q         <= count_q + CntW'(1);
                                end
                            end
                            CmdRun: begin
                                if (!empty) begin
                                    state_q <= StSum;
                                end
                            end
                            CmdClear: begin
                                acc_q    <= '0;
                                ovf_q    <= 1'b0;
                                wr_ptr_q <= '0;
                                rd_ptr_q <= '0;
                                count_q  <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                StSum: begin
                    // Pulses arriving here are dropped; the FIFO is only drained.
                    acc_q[7:0]  <= sum[7:0];
                    acc_q[15:8] <= acc_q[15:8] + {7'b0, carry};
                    if ((acc_q[15:8] == 8'hFF) && carry) begin
                        ovf_q <= 1'b1;
                    end
                    rd_ptr_q <= rd_ptr_q + PtrW'(1);
                    count_q  <= count_q - CntW'(1);
                    if (count_q == CntW'(1)) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign uo_out  = byte_sel ? acc_q[15:8] : acc_q[7:0];
    assign uio_out = {ovf_q, full, empty, busy, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_heichips25_accum_sequencer.sv
// Directed bench for the accumulator sequencer: reset, sums, FIFO limits,
// command guards, overflow wrap and asynchronous reset during a run.
module tb_heichips25_accum_sequencer;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic       stb;
    logic [1:0] cmd;
    logic       sel;

    int n_checks;
    int n_fail;

    assign uio_in = {4'h0, sel, cmd, stb};

    heichips25_accum_sequencer #(
        .DEPTH      (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full handshake: stb held 4 cycles, then low 4 cycles so the next one re-arms.
    task automatic do_cmd(input logic [1:0] c, input logic [7:0] d);
        @(negedge clk);
        cmd   = c;
        ui_in = d;
        stb   = 1'b1;
        repeat (4) @(negedge clk);
        stb = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic read_acc(output logic [15:0] v);
        sel = 1'b0;
        #1;
        v[7:0] = uo_out;
        sel = 1'b1;
        #1;
        v[15:8] = uo_out;
        sel = 1'b0;
        #1;
    endtask

    task automatic load4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        do_cmd(2'b00, a);
        do_cmd(2'b00, b);
        do_cmd(2'b00, c);
        do_cmd(2'b00, d);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        stb   = 1'b0;
        cmd   = 2'b11;
        sel   = 1'b0;
        ui_in = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if (uo_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_uo_out: got %h expected 00", uo_out);
        end
        n_checks++;
        if (uio_out !== 8'h20) begin
            n_fail++;
            $display("FAIL reset_uio_out: got %h expected 20", uio_out);
        end
        n_checks++;
        if (uio_oe !== 8'hF0) begin
            n_fail++;
            $display("FAIL reset_uio_oe: got %h expected F0", uio_oe);
        end
        sel = 1'b1;
        #1;
        n_checks++;
        if (uo_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_uo_out_hi: got %h expected 00", uo_out);
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_sum;
        logic [15:0] acc;
        int          busy_cycles;
        logic        busy_n2;
        logic        busy_n3;
        load4(8'h80, 8'h90, 8'h7F, 8'h11);
        busy_cycles = 0;
        busy_n2     = 1'b0;
        busy_n3     = 1'b0;
        @(negedge clk);
        cmd = 2'b01;
        stb = 1'b1;
        // stb stays high for the whole window: exactly one RUN must result
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 2) busy_n2 = uio_out[4];
            if (i == 3) busy_n3 = uio_out[4];
            if (uio_out[4]) busy_cycles++;
        end
        stb = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy_n2 !== 1'b0 || busy_n3 !== 1'b1) begin
            n_fail++;
            $display("FAIL run_latency: got busy %b,%b expected 0,1", busy_n2, busy_n3);
        end
        n_checks++;
        if (busy_cycles != 4) begin
            n_fail++;
            $display("FAIL busy_cycles: got %0d expected 4", busy_cycles);
        end
        read_acc(acc);
        n_checks++;
        if (acc !== 16'h01A0) begin
            n_fail++;
            $display("FAIL basic_sum_acc: got %h expected 01A0", acc);
        end
        n_checks++;
        if (uio_out !== 8'h20) begin
            n_fail++;
            $display("FAIL basic_sum_status: got %h expected 20", uio_out);
        end
    endtask

    task automatic test_full_drop;
        logic [15:0] acc;
        do_cmd(2'b10, 8'h00);
        load4(8'h01, 8'h02, 8'h03, 8'h04);
        n_checks++;
        if (uio_out !== 8'h40) begin
            n_fail++;
            $display("FAIL full_flag: got %h expected 40", uio_out);
        end
        do_cmd(2'b00, 8'h55);
        n_checks++;
        if (uio_out !== 8'h40) begin
            n_fail++;
            $display("FAIL drop_status: got %h expected 40", uio_out);
        end
        do_cmd(2'b01, 8'h00);
        read_acc(acc);
        n_checks++;
        if (acc !== 16'h000A) begin
            n_fail++;
            $display("FAIL full_drop_acc: got %h expected 000A", acc);
        end
        n_checks++;
        if (uio_out !== 8'h20) begin
            n_fail++;
            $display("FAIL full_drop_status: got %h expected 20", uio_out);
        end
    endtask

    task automatic test_run_empty;
        logic [15:0] acc;
        logic        saw_busy;
        saw_busy = 1'b0;
        @(negedge clk);
        cmd = 2'b01;
        stb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (uio_out[4]) saw_busy = 1'b1;
        end
        stb = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (saw_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL run_empty_busy: got %b expected 0", saw_busy);
        end
        read_acc(acc);
        n_checks++;
        if (acc !== 16'h000A) begin
            n_fail++;
            $display("FAIL run_empty_acc: got %h expected 000A", acc);
        end
    endtask

    // RUN pulse, then a second strobe whose command lands while SUM is active.
    task automatic run_with_intrusion(input logic [1:0] c, input logic [7:0] d,
                                      output logic busy_at_n5);
        @(negedge clk);
        cmd = 2'b01;
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cmd   = c;
        ui_in = d;
        stb   = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        @(negedge clk);
        busy_at_n5 = uio_out[4];
        repeat (8) @(negedge clk);
    endtask

    task automatic test_guards;
        logic [15:0] acc;
        logic        b;
        do_cmd(2'b10, 8'h00);
        load4(8'h10, 8'h20, 8'h30, 8'h40);
        run_with_intrusion(2'b00, 8'h33, b);
        n_checks++;
        if (b !== 1'b1) begin
            n_fail++;
            $display("FAIL guard_load_in_sum: got busy %b expected 1", b);
        end
        read_acc(acc);
        n_checks++;
        if (acc !== 16'h00A0 || uio_out !== 8'h20) begin
            n_fail++;
            $display("FAIL guard_load: got acc %h status %h expected 00A0 20", acc, uio_out);
        end
        load4(8'h01, 8'h02, 8'h03, 8'h04);
        run_with_intrusion(2'b10, 8'h00, b);
        read_acc(acc);
        n_checks++;
        if (acc !== 16'h00AA || uio_out !== 8'h20) begin
            n_fail++;
            $display("FAIL guard_clear: got acc %h status %h expected 00AA 20", acc, uio_out);
        end
    endtask

    task automatic test_overflow;
        logic [15:0] acc;
        do_cmd(2'b10, 8'h00);
        for (int r = 0; r < 65; r++) begin
            load4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
            do_cmd(2'b01, 8'h00);
            if (r == 63) begin
                read_acc(acc);
                n_checks++;
                if (acc !== 16'hFF00 || uio_out[7] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL pre_overflow: got acc %h ovf %b expected FF00 0",
                             acc, uio_out[7]);
                end
            end
        end
        read_acc(acc);
        n_checks++;
        if (acc !== 16'h02FC) begin
            n_fail++;
            $display("FAIL overflow_acc: got %h expected 02FC", acc);
        end
        n_checks++;
        if (uio_out !== 8'hA0) begin
            n_fail++;
            $display("FAIL overflow_status: got %h expected A0", uio_out);
        end
        do_cmd(2'b10, 8'h00);
        read_acc(acc);
        n_checks++;
        if (acc !== 16'h0000 || uio_out !== 8'h20) begin
            n_fail++;
            $display("FAIL clear_after_ovf: got acc %h status %h expected 0000 20", acc, uio_out);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] acc;
        logic        rose;
        load4(8'h01, 8'h02, 8'h03, 8'h04);
        @(negedge clk);
        cmd  = 2'b01;
        stb  = 1'b1;
        rose = 1'b0;
        for (int i = 0; i < 10 && !rose; i++) begin
            @(negedge clk);
            if (uio_out[4]) rose = 1'b1;
        end
        n_checks++;
        if (!rose) begin
            n_fail++;
            $display("FAIL mid_busy_rise: got busy 0 expected 1 within 10 cycles");
        end
        @(negedge clk);
        rst_n = 1'b0;
        stb   = 1'b0;
        #1;
        read_acc(acc);
        n_checks++;
        if (acc !== 16'h0000 || uio_out !== 8'h20 || uio_oe !== 8'hF0) begin
            n_fail++;
            $display("FAIL mid_reset: got acc %h status %h oe %h expected 0000 20 F0",
                     acc, uio_out, uio_oe);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_cmd(2'b00, 8'h07);
        do_cmd(2'b01, 8'h00);
        read_acc(acc);
        n_checks++;
        if (acc !== 16'h0007 || uio_out !== 8'h20) begin
            n_fail++;
            $display("FAIL post_reset_sum: got acc %h status %h expected 0007 20", acc, uio_out);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ena      = 1'b1;
        rst_n    = 1'b0;
        stb      = 1'b0;
        cmd      = 2'b11;
        sel      = 1'b0;
        ui_in    = 8'h00;
        test_reset;
        test_basic_sum;
        test_full_drop;
        test_run_empty;
        test_guards;
        test_overflow;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
